// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command scheduler: command codes, scheduler
// states and the (cs_n, ras_n, cas_n, we_n) pin encodings.
package dram_pkg;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_COL = 2'b01;
  localparam logic [1:0] CMD_REF = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } sched_state_e;

  localparam logic [3:0] PINS_NOP = 4'b0111;
  localparam logic [3:0] PINS_ACT = 4'b0011;
  localparam logic [3:0] PINS_COL = 4'b0101;
  localparam logic [3:0] PINS_PRE = 4'b0010;
  localparam logic [3:0] PINS_REF = 4'b0001;

  function automatic logic [3:0] cmd_pins(input logic [1:0] cmd);
    logic [3:0] pins;
    pins = PINS_NOP;
    case (cmd)
      CMD_ACT: pins = PINS_ACT;
      CMD_COL: pins = PINS_COL;
      CMD_REF: pins = PINS_REF;
      CMD_PRE: pins = PINS_PRE;
      default: pins = PINS_NOP;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/dram_cmd_sched_if.sv
// Command handshake from the controller FSM plus the DRAM command pins.
// master = controller side, slave = scheduler side.
interface dram_cmd_sched_if #(
  parameter int BA_W   = 3,
  parameter int ADDR_W = 7,
  parameter int COL_W  = 3
);

  logic              cmd_req;
  logic [1:0]        cmd;
  logic [BA_W-1:0]   bank_id;
  logic [ADDR_W-1:0] row_id;
  logic [COL_W-1:0]  col_id;
  logic              cmd_ack;
  logic              refresh_flag;
  logic              refresh_overrun;
  logic              busy;
  logic              dram_cs_n;
  logic              dram_ras_n;
  logic              dram_cas_n;
  logic              dram_we_n;
  logic [BA_W-1:0]   dram_ba;
  logic [ADDR_W-1:0] dram_addr;

  modport master (
    output cmd_req, cmd, bank_id, row_id, col_id,
    input  cmd_ack, refresh_flag, refresh_overrun, busy,
    input  dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, dram_addr
  );

  modport slave (
    input  cmd_req, cmd, bank_id, row_id, col_id,
    output cmd_ack, refresh_flag, refresh_overrun, busy,
    output dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ba, dram_addr
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer; raises refresh_flag every T_REFI cycles
// and latches refresh_overrun if an interval expires with the flag still set.
module dram_refresh_timer #(
  parameter int T_REFI = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_done,
  output logic refresh_flag,
  output logic refresh_overrun
);

  localparam int CNT_W = $clog2(T_REFI);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             ovr_q, ovr_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(T_REFI - 1));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    flag_d = flag_q;
    ovr_d  = ovr_q | (wrap & flag_q);
    if (ref_done) flag_d = 1'b0;
    // A wrap coinciding with the REF completion still counts as a new request.
    if (wrap)     flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      ovr_q  <= ovr_d;
    end
  end

  assign refresh_flag    = flag_q;
  assign refresh_overrun = ovr_q;

endmodule

// File: rtl/dram_cmd_sched.sv
// DRAM command scheduler: issues one command at a time on registered pins,
// holds it for its JEDEC latency, acks it, and guards PRE against tRAS.
module dram_cmd_sched
  import dram_pkg::*;
#(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int T_RCD           = 3,
  parameter int T_CL            = 3,
  parameter int T_RP            = 3,
  parameter int T_RFC           = 10,
  parameter int T_RAS           = 7,
  parameter int T_REFI          = 780
) (
  input logic          clk,
  input logic          rst,
  dram_cmd_sched_if.slave bus
);

  localparam int BA_W     = $clog2(NUMBER_OF_BANKS);
  localparam int ADDR_W   = $clog2(NUMBER_OF_ROWS);
  localparam int COL_W    = $clog2(NUMBER_OF_COLS);
  localparam int LAT_MAX_A = (T_RCD > T_CL) ? T_RCD : T_CL;
  localparam int LAT_MAX_B = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int LAT_MAX   = (LAT_MAX_A > LAT_MAX_B) ? LAT_MAX_A : LAT_MAX_B;
  localparam int LAT_W     = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int RAS_W     = (T_RAS > 1) ? $clog2(T_RAS) : 1;
  localparam int RAS_LOAD  = (T_RAS > 0) ? T_RAS - 1 : 0;

  function automatic logic [LAT_W-1:0] lat_load(input logic [1:0] c);
    logic [LAT_W-1:0] v;
    v = LAT_W'(T_RCD - 1);
    case (c)
      CMD_ACT: v = LAT_W'(T_RCD - 1);
      CMD_COL: v = LAT_W'(T_CL - 1);
      CMD_REF: v = LAT_W'(T_RFC - 1);
      CMD_PRE: v = LAT_W'(T_RP - 1);
      default: v = LAT_W'(T_RCD - 1);
    endcase
    return v;
  endfunction

  sched_state_e      state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [RAS_W-1:0]  tras_q, tras_d;
  logic [3:0]        pins_q, pins_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pre_blocked;
  logic              ref_done;

  assign pre_blocked = (bus.cmd == CMD_PRE) && (tras_q != '0);

  // The pin registers double as the held bank/address of the accepted command.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    lat_d   = lat_q;
    tras_d  = tras_q;
    pins_d  = PINS_NOP;
    ba_d    = '0;
    addr_d  = '0;
    if (tras_q != '0) tras_d = tras_q - RAS_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_req && !pre_blocked) begin
          state_d = ST_ISSUE;
          cmd_d   = bus.cmd;
          pins_d  = cmd_pins(bus.cmd);
          case (bus.cmd)
            CMD_ACT: begin
              ba_d   = bus.bank_id;
              addr_d = bus.row_id;
            end
            CMD_COL: begin
              ba_d   = bus.bank_id;
              addr_d = ADDR_W'(bus.col_id);
            end
            CMD_PRE: ba_d = bus.bank_id;
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        lat_d   = lat_load(cmd_q);
        state_d = (lat_load(cmd_q) == '0) ? ST_ACK : ST_WAIT;
        if (cmd_q == CMD_ACT) tras_d = RAS_W'(RAS_LOAD);
      end
      ST_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      tras_q  <= '0;
      pins_q  <= PINS_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tras_q  <= tras_d;
      pins_q  <= pins_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

  // Clearing on entry to ACK keeps refresh_flag low during the ack cycle itself.
  assign ref_done = (state_d == ST_ACK) && (cmd_q == CMD_REF);

  dram_refresh_timer #(
    .T_REFI (T_REFI)
  ) u_refresh_timer (
    .clk             (clk),
    .rst             (rst),
    .ref_done        (ref_done),
    .refresh_flag    (bus.refresh_flag),
    .refresh_overrun (bus.refresh_overrun)
  );

  assign bus.cmd_ack    = (state_q == ST_ACK);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.dram_cs_n  = pins_q[3];
  assign bus.dram_ras_n = pins_q[2];
  assign bus.dram_cas_n = pins_q[1];
  assign bus.dram_we_n  = pins_q[0];
  assign bus.dram_ba    = ba_q;
  assign bus.dram_addr  = addr_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched (built with T_CL=1, other timings default).
module tb_dram_cmd_sched;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  dram_cmd_sched_if #(.BA_W(3), .ADDR_W(7), .COL_W(3)) bus ();

  dram_cmd_sched #(.T_CL(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] pins;
  assign pins = {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    bus.cmd = CMD_ACT; bus.bank_id = '0; bus.row_id = '0; bus.col_id = '0;
    do_reset();
    total++; if (pins !== PINS_NOP) $display("FAIL reset_pins got %b want %b", pins, PINS_NOP); else passed++;
    total++; if (bus.dram_ba !== 3'd0 || bus.dram_addr !== 7'd0) $display("FAIL reset_ba_addr got %0d/%0d want 0/0", bus.dram_ba, bus.dram_addr); else passed++;
    total++; if (bus.cmd_ack !== 1'b0 || bus.busy !== 1'b0) $display("FAIL reset_ack_busy got %b%b want 00", bus.cmd_ack, bus.busy); else passed++;
    total++; if (bus.refresh_flag !== 1'b0 || bus.refresh_overrun !== 1'b0) $display("FAIL reset_refresh got %b%b want 00", bus.refresh_flag, bus.refresh_overrun); else passed++;
  endtask

  task automatic test_act();
    logic exp_ack;
    bus.cmd_req = 1'b1; bus.cmd = CMD_ACT; bus.bank_id = 3'd3; bus.row_id = 7'h55;
    tick();
    total++; if (pins !== PINS_ACT) $display("FAIL act_pins got %b want %b", pins, PINS_ACT); else passed++;
    total++; if (bus.dram_ba !== 3'd3 || bus.dram_addr !== 7'h55) $display("FAIL act_ba_addr got %0d/%h want 3/55", bus.dram_ba, bus.dram_addr); else passed++;
    total++; if (bus.busy !== 1'b1 || bus.cmd_ack !== 1'b0) $display("FAIL act_issue_busy_ack got %b%b want 10", bus.busy, bus.cmd_ack); else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_ack = (i == 3);
      total++; if (bus.cmd_ack !== exp_ack) $display("FAIL act_ack_k+%0d got %b want %b", i, bus.cmd_ack, exp_ack); else passed++;
      total++; if (bus.busy !== 1'b1) $display("FAIL act_busy_k+%0d got %b want 1", i, bus.busy); else passed++;
    end
    total++; if (pins !== PINS_NOP) $display("FAIL act_pins_after got %b want %b", pins, PINS_NOP); else passed++;
    // cmd_req still held through the ACK cycle: must not be re-accepted there
    tick();
    bus.cmd_req = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.cmd_ack !== 1'b0) $display("FAIL act_no_double_accept got busy=%b ack=%b want 0 0", bus.busy, bus.cmd_ack); else passed++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL act_idle got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_col_fast();
    bus.cmd_req = 1'b1; bus.cmd = CMD_COL; bus.bank_id = 3'd1; bus.col_id = 3'd5;
    tick();
    bus.cmd_req = 1'b0;
    total++; if (pins !== PINS_COL) $display("FAIL col_pins got %b want %b", pins, PINS_COL); else passed++;
    total++; if (bus.dram_ba !== 3'd1 || bus.dram_addr !== 7'd5) $display("FAIL col_ba_addr got %0d/%0d want 1/5", bus.dram_ba, bus.dram_addr); else passed++;
    tick();
    total++; if (bus.cmd_ack !== 1'b1 || bus.busy !== 1'b1) $display("FAIL col_ack_k+1 got ack=%b busy=%b want 1 1", bus.cmd_ack, bus.busy); else passed++;
    tick();
    total++; if (bus.cmd_ack !== 1'b0 || bus.busy !== 1'b0) $display("FAIL col_done got ack=%b busy=%b want 0 0", bus.cmd_ack, bus.busy); else passed++;
  endtask

  task automatic test_act_then_pre();
    int  k;
    int  p;
    bit  found;
    bus.cmd_req = 1'b1; bus.cmd = CMD_ACT; bus.bank_id = 3'd2; bus.row_id = 7'h12;
    tick();
    k = cyc;
    total++; if (pins !== PINS_ACT) $display("FAIL ap_act_pins got %b want %b", pins, PINS_ACT); else passed++;
    tick(); tick(); tick();
    total++; if (bus.cmd_ack !== 1'b1) $display("FAIL ap_act_ack got %b want 1", bus.cmd_ack); else passed++;
    bus.cmd = CMD_PRE;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL ap_pre_held_off got busy=%b want 0", bus.busy); else passed++;
    found = 1'b0;
    p = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (pins === PINS_PRE) begin
        found = 1'b1;
        p = cyc;
      end
    end
    bus.cmd_req = 1'b0;
    total++; if (!found) $display("FAIL ap_pre_issue got none want PRE within 12 cycles"); else passed++;
    total++; if (found && (p - k < 7 || p - k > 8)) $display("FAIL ap_pre_tras got offset %0d want 7..8", p - k); else passed++;
    total++; if (bus.dram_ba !== 3'd2 || bus.dram_addr !== 7'd0) $display("FAIL ap_pre_ba_addr got %0d/%0d want 2/0", bus.dram_ba, bus.dram_addr); else passed++;
    tick(); tick();
    total++; if (bus.cmd_ack !== 1'b0) $display("FAIL ap_pre_early_ack got %b want 0", bus.cmd_ack); else passed++;
    tick();
    total++; if (bus.cmd_ack !== 1'b1) $display("FAIL ap_pre_ack_p+3 got %b want 1", bus.cmd_ack); else passed++;
    tick();
  endtask

  task automatic test_refresh();
    do_reset();
    while (cyc < 779) tick();
    total++; if (bus.refresh_flag !== 1'b0) $display("FAIL ref_flag_779 got %b want 0", bus.refresh_flag); else passed++;
    tick();
    total++; if (bus.refresh_flag !== 1'b1) $display("FAIL ref_flag_780 got %b want 1", bus.refresh_flag); else passed++;
    bus.cmd_req = 1'b1; bus.cmd = CMD_REF; bus.bank_id = 3'd5;
    tick();
    bus.cmd_req = 1'b0;
    total++; if (pins !== PINS_REF) $display("FAIL ref_pins got %b want %b", pins, PINS_REF); else passed++;
    total++; if (bus.dram_ba !== 3'd0 || bus.dram_addr !== 7'd0) $display("FAIL ref_ba_addr got %0d/%0d want 0/0", bus.dram_ba, bus.dram_addr); else passed++;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (bus.cmd_ack !== 1'b0) $display("FAIL ref_early_ack_k+%0d got %b want 0", i, bus.cmd_ack); else passed++;
    end
    total++; if (bus.refresh_flag !== 1'b1) $display("FAIL ref_flag_wait got %b want 1", bus.refresh_flag); else passed++;
    tick();
    total++; if (bus.cmd_ack !== 1'b1) $display("FAIL ref_ack_k+10 got %b want 1", bus.cmd_ack); else passed++;
    total++; if (bus.refresh_flag !== 1'b0) $display("FAIL ref_flag_clear got %b want 0", bus.refresh_flag); else passed++;
    tick();
    total++; if (bus.cmd_ack !== 1'b0 || bus.refresh_flag !== 1'b0) $display("FAIL ref_after got ack=%b flag=%b want 0 0", bus.cmd_ack, bus.refresh_flag); else passed++;
  endtask

  task automatic test_overrun();
    bit got_ack;
    while (cyc < 1560) tick();
    total++; if (bus.refresh_flag !== 1'b1 || bus.refresh_overrun !== 1'b0) $display("FAIL ovr_1560 got flag=%b ovr=%b want 1 0", bus.refresh_flag, bus.refresh_overrun); else passed++;
    while (cyc < 2339) tick();
    total++; if (bus.refresh_overrun !== 1'b0) $display("FAIL ovr_2339 got %b want 0", bus.refresh_overrun); else passed++;
    tick();
    total++; if (bus.refresh_overrun !== 1'b1) $display("FAIL ovr_2340 got %b want 1", bus.refresh_overrun); else passed++;
    bus.cmd_req = 1'b1; bus.cmd = CMD_REF;
    tick();
    bus.cmd_req = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 15 && !got_ack; i++) begin
      tick();
      got_ack = bus.cmd_ack;
    end
    total++; if (!got_ack) $display("FAIL ovr_ref_ack got none want ack within 15 cycles"); else passed++;
    total++; if (bus.refresh_flag !== 1'b0 || bus.refresh_overrun !== 1'b1) $display("FAIL ovr_sticky got flag=%b ovr=%b want 0 1", bus.refresh_flag, bus.refresh_overrun); else passed++;
    tick(); tick();
    total++; if (bus.refresh_overrun !== 1'b1) $display("FAIL ovr_sticky_later got %b want 1", bus.refresh_overrun); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen_ack;
    while (cyc < 3120) tick();
    total++; if (bus.refresh_flag !== 1'b1) $display("FAIL rm_flag_pre got %b want 1", bus.refresh_flag); else passed++;
    bus.cmd_req = 1'b1; bus.cmd = CMD_REF;
    tick();
    bus.cmd_req = 1'b0;
    tick(); tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL rm_in_wait got busy=%b want 1", bus.busy); else passed++;
    rst = 1'b1;
    tick();
    total++; if (pins !== PINS_NOP || bus.dram_ba !== 3'd0 || bus.dram_addr !== 7'd0) $display("FAIL rm_pins got %b ba=%0d addr=%0d want %b 0 0", pins, bus.dram_ba, bus.dram_addr, PINS_NOP); else passed++;
    total++; if (bus.cmd_ack !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rm_ack_busy got %b%b want 00", bus.cmd_ack, bus.busy); else passed++;
    total++; if (bus.refresh_flag !== 1'b0 || bus.refresh_overrun !== 1'b0) $display("FAIL rm_refresh got %b%b want 00", bus.refresh_flag, bus.refresh_overrun); else passed++;
    rst = 1'b0;
    cyc = 0;
    seen_ack = 1'b0;
    while (cyc < 20) begin
      tick();
      if (bus.cmd_ack === 1'b1) seen_ack = 1'b1;
    end
    total++; if (seen_ack) $display("FAIL rm_abandoned got ack=1 want no ack"); else passed++;
    while (cyc < 779) tick();
    total++; if (bus.refresh_flag !== 1'b0) $display("FAIL rm_timer_779 got %b want 0", bus.refresh_flag); else passed++;
    tick();
    total++; if (bus.refresh_flag !== 1'b1) $display("FAIL rm_timer_780 got %b want 1", bus.refresh_flag); else passed++;
  endtask

  initial begin
    bus.cmd_req = 1'b0;
    bus.cmd     = CMD_ACT;
    bus.bank_id = '0;
    bus.row_id  = '0;
    bus.col_id  = '0;
    test_reset();
    test_act();
    test_col_fast();
    test_act_then_pre();
    test_refresh();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dram_cmd_sched.md
Name: dram_cmd_sched

Overview:
- Downstream neighbour of the controller FSM. Consumes its cmd_req/cmd handshake plus bank/row/col, and drives the DRAM command pins (cs_n/ras_n/cas_n/we_n, ba, addr).
- Enforces JEDEC-style timing (tRCD, tCL, tRP, tRAS, tRFC) and returns a one-cycle cmd_ack once the command's timing window has closed.
- Also owns the periodic refresh interval timer, and produces the refresh_flag that the FSM samples.

Parameters:
- NUMBER_OF_BANKS, 8, bank count; BA_W = $clog2(NUMBER_OF_BANKS)
- NUMBER_OF_ROWS, 128, row count; ADDR_W = $clog2(NUMBER_OF_ROWS)
- NUMBER_OF_COLS, 8, column count; COL_W = $clog2(NUMBER_OF_COLS), must be <= ADDR_W
- T_RCD, 3, ACT-to-ack cycles (>=1)
- T_CL, 3, column-access-to-ack cycles (>=1)
- T_RP, 3, PRE-to-ack cycles (>=1)
- T_RFC, 10, REF-to-ack cycles (>=1)
- T_RAS, 7, minimum cycles from ACT issue to PRE issue
- T_REFI, 780, refresh interval in cycles (>=2)

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous, active-high reset
- cmd_req, in, 1, command request, level, from FSM
- cmd, in, 2, command code: 00 ACT, 01 COL (read), 10 REF, 11 PRE
- bank_id, in, BA_W, target bank
- row_id, in, ADDR_W, row for ACT
- col_id, in, COL_W, column for COL
- cmd_ack, out, 1, one-cycle pulse; command timing complete
- refresh_flag, out, 1, refresh due; held until a REF is acked
- refresh_overrun, out, 1, sticky; a full T_REFI elapsed while refresh was still pending
- busy, out, 1, FSM not in IDLE
- dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, out, 1 each, registered command pins
- dram_ba, out, BA_W, registered bank address
- dram_addr, out, ADDR_W, registered address

Behaviour:
- Reset values:
  - Pins = NOP (cs_n=0, ras_n=1, cas_n=1, we_n=1); ba=0, addr=0.
  - cmd_ack=0, busy=0, refresh_flag=0, refresh_overrun=0.
  - Refresh timer=0, tRAS counter=0, state=IDLE.
- Reset mid-operation: all of the above take effect on the next edge. An in-flight command is abandoned and no ack is issued.
- Pin encodings (cs,ras,cas,we):
  - ACT 0011, ba=bank_id, addr=row_id
  - COL 0101, ba=bank_id, addr=col_id zero-extended
  - PRE 0010, ba=bank_id, addr=0
  - REF 0001, ba=0, addr=0
  - Any non-ISSUE cycle drives NOP.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Go to ISSUE when cmd_req=1.
  - Exception: if cmd=PRE and tras_cnt!=0, remain in IDLE until tras_cnt==0.
  - cmd, bank_id, row_id and col_id are captured into a holding register on the accept edge.
- ISSUE:
  - One cycle; pins show the captured command.
  - Latency counter loads T-1, where T is per command (T_RCD / T_CL / T_RFC / T_RP).
  - Next state is WAIT if T>1, else ACK.
- WAIT: decrement each cycle; at 0 go to ACK.
- ACK: cmd_ack=1 for exactly this cycle, then IDLE.
- Timing rule: if ISSUE occupies cycle k, cmd_ack is high in cycle k+T.
- No double accept: cmd_req sampled in the ACK cycle is ignored. A new command is accepted only from IDLE.
- tRAS counter:
  - Loaded with T_RAS-1 in the ACT ISSUE cycle, decrements to 0 and saturates there.
  - Single global counter (covers last ACT only).
- Refresh timer:
  - Free-running, 0..T_REFI-1, wraps.
  - On wrap: if refresh_flag is already 1, set refresh_overrun; then set refresh_flag.
  - refresh_flag clears in the ACK cycle of a REF command.
  - If the timer wraps in that same ACK cycle, set wins: flag stays 1.
- Counter widths are $clog2(max value + 1). There is no arithmetic wrap apart from the refresh timer.
- busy = (state != IDLE).

Decomposition:
- Shared package dram_pkg holds:
  - cmd code localparams (CMD_ACT=2'b00, CMD_COL=2'b01, CMD_REF=2'b10, CMD_PRE=2'b11)
  - scheduler state encodings
  - 4-bit pin-encoding constants
- One natural sub-module, dram_refresh_timer: T_REFI counter plus the refresh_flag/overrun logic. Its inputs are clk, rst and ref_done; its outputs are refresh_flag and refresh_overrun.

Test Plan:
- ACT bank 3 row 0x55, cmd_req held:
  - ISSUE cycle k shows pins 0011, ba=3, addr=0x55.
  - cmd_ack pulses only in k+3.
  - busy is high for k..k+3.
- COL col 5 with T_CL=1: ISSUE pins 0101, addr=5; cmd_ack in k+1; the WAIT state is skipped.
- ACT, then PRE requested immediately after the ACT ack:
  - PRE ISSUE is no earlier than ACT ISSUE + 7.
  - Ack comes 3 cycles later.
- Let the timer run 780 cycles:
  - refresh_flag rises.
  - REF with T_RFC=10 acks 10 cycles after issue, and the flag clears in the ack cycle.
- Leave the flag unserviced for a further 780 cycles: refresh_overrun goes to 1 and stays 1 through a later REF ack, until rst.
- Assert rst during WAIT of a REF:
  - Next cycle: pins NOP, no cmd_ack, state IDLE, refresh_flag=0, timer restarts from 0.
